// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter for two byte requesters feeding one 8N1 serial transmitter.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tx_arbiter #(
  parameter int BAUD_DIV = 345
) (
  input  logic       c,
  input  logic       r,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant
);
`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  sel_data;
  logic        last;
  logic        bit_end;
`ifdef TX_PARITY_EN
  logic        par;
`endif
  // last holds the most recent winner, so a tie goes to the other requester
  always_comb begin
    req0_ready = state == IDLE && !r && req0_valid && (!req1_valid || last);
    req1_ready = state == IDLE && !r && req1_valid && (!req0_valid || !last);
    sel_data   = req1_ready ? req1_data : req0_data;
    bit_end    = cnt == 16'd0;
  end
  always_ff @(posedge c) begin
    if (r) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      grant   <= 1'b0;
      last    <= 1'b1;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
`ifdef TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      if (state != IDLE) cnt <= bit_end ? RELOAD : cnt - 16'd1;
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          shreg <= sel_data;
          grant <= req1_ready;
          last  <= req1_ready;
          tx    <= 1'b0;
          busy  <= 1'b1;
          cnt   <= RELOAD;
          state <= START;
`ifdef TX_PARITY_EN
          par   <= ^sel_data;
`endif
        end
        START: if (bit_end) begin
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= 3'd0;
          state   <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
            tx    <= par;
            state <= PARITY;
`else
            tx    <= 1'b1;
            state <= STOP;
`endif
          end else begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
`ifdef TX_PARITY_EN
        PARITY: if (bit_end) begin
          tx    <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: random and directed traffic; a cycle-count model predicts handshakes and frames, a serial decoder checks them.
module tb_tx_arbiter;
  localparam int B = 4;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * B;
  typedef struct {
    logic       g;
    logic [7:0] d;
    int         t0;
  } exp_t;
  logic c = 0, r = 1, v0 = 0, v1 = 0;
  logic [7:0] d0 = 0, d1 = 0;
  logic req0_ready, req1_ready, tx, busy, grant;
  logic a0 = 0, a1 = 0, g0 = 0;
  int total = 0, bad = 0, cyc = 0, frames = 0;
  tx_arbiter #(.BAUD_DIV(B)) dut (
    .c(c), .r(r),
    .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant(grant)
  );
  always #5 c = ~c;
  always @(posedge c) cyc++;
  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction
  // model: idle unless a frame accepted within the last FR cycles; ties go to the requester not granted last
  exp_t q[$];
  int blk = 0;
  logic lastg = 1, gexp = 0, r_prev = 0, e0, e1;
  always @(negedge c) begin
    if (r_prev) begin
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant", int'(grant), 0);
    end
    if (r) begin
      chk("rst_ready", int'({req0_ready, req1_ready}), 0);
      blk = 0; lastg = 1; gexp = 0;
      q.delete();
    end else begin
      e0 = blk == 0 && v0 && (!v1 || lastg);
      e1 = blk == 0 && v1 && (!v0 || !lastg);
      chk("ready0", int'(req0_ready), int'(e0));
      chk("ready1", int'(req1_ready), int'(e1));
      chk("busy", int'(busy), int'(blk != 0));
      chk("grant", int'(grant), int'(gexp));
      if (e0 || e1) begin
        q.push_back('{g: e1, d: e1 ? d1 : d0, t0: cyc + 1});
        lastg = e1; gexp = e1; blk = FR;
      end else if (blk > 0) blk--;
    end
    r_prev = r;
  end
  // monitor: decode tx, demand each bit constant for B cycles, pop and compare at end of stop bit
  int mi = 0, st = 0;
  logic mact = 0;
  logic [10:0] bitv;
  exp_t ex;
  always @(negedge c) begin
    if (r) mact = 0;
    else if (!mact) begin
      if (!tx) begin
        mact = 1; mi = 1; st = cyc; bitv = '0;
      end
    end else begin
      if (mi % B == 0) bitv[mi / B] = tx;
      else chk("bit_hold", int'(tx), int'(bitv[mi / B]));
      if (mi == FR - 1) begin
        mact = 0;
        frames++;
        chk("stop_bit", int'(bitv[NB - 1]), 1);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL frame_unexpected at cycle %0d: got data %0h expected no frame", cyc, bitv[8:1]);
        end else begin
          ex = q.pop_front();
          chk("data", int'(bitv[8:1]), int'(ex.d));
          chk("frame_grant", int'(grant), int'(ex.g));
          chk("frame_start", st, ex.t0);
`ifdef TX_PARITY_EN
          chk("parity", int'(bitv[9]), int'(^ex.d));
`endif
        end
      end
      mi++;
    end
  end
  task automatic step();
    @(negedge c);
    a0 = v0 && req0_ready;
    a1 = v1 && req1_ready;
    @(posedge c);
    #1;
  endtask
  task automatic send(input logic w0, input logic w1, input logic [7:0] x0, input logic [7:0] x1);
    logic h0, h1;
    h0 = !w0; h1 = !w1;
    v0 = w0; d0 = x0; v1 = w1; d1 = x1;
    for (int n = 0; n < 200 && !(h0 && h1); n++) begin
      step();
      if (a0) begin v0 = 0; h0 = 1; end
      if (a1) begin v1 = 0; h1 = 1; end
    end
    chk("send_accept", int'({h0, h1}), 3);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 200 && (busy || q.size() != 0 || mact)) begin step(); n++; end
    chk("idle_reached", int'(busy || q.size() != 0 || mact), 0);
    step();
  endtask
  initial begin
    repeat (3) step();
    r = 0;
    send(1, 0, 8'h55, 8'h00);
    wait_idle();
    send(1, 1, 8'hA1, 8'h3C);
    wait_idle();
    send(1, 1, 8'h5A, 8'hC3);
    wait_idle();
    v1 = 1; d1 = 8'hFF; g0 = 0;
    for (int n = 0; n < 150 && !g0; n++) begin
      step();
      if (n == 10) begin v0 = 1; d0 = 8'h12; end
      if (a0) begin v0 = 0; g0 = 1; end
    end
    v1 = 0;
    chk("rr_mid_frame", int'(g0), 1);
    wait_idle();
    send(1, 0, 8'h07, 8'h00);
    repeat (17) step();
    r = 1;
    step();
    r = 0;
    send(1, 0, 8'h3B, 8'h00);
    wait_idle();
    send(1, 0, 8'h03, 8'h00);
    wait_idle();
    for (int n = 0; n < 3000; n++) begin
      step();
      if (a0) begin v0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom); end
      else if (!v0) begin if ($urandom_range(0, 3) == 0) begin v0 = 1; d0 = 8'($urandom); end end
      else if ($urandom_range(0, 15) == 0) v0 = 0;
      else if (busy) d0 = 8'($urandom);
      if (a1) begin v1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom); end
      else if (!v1) begin if ($urandom_range(0, 3) == 0) begin v1 = 1; d1 = 8'($urandom); end end
      else if ($urandom_range(0, 15) == 0) v1 = 0;
      else if (busy) d1 = 8'($urandom);
    end
    v0 = 0; v1 = 0;
    wait_idle();
    chk("frames_seen", int'(frames > 20), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
